step_pulse_gen: RTL

- Upstream stage for the free-running 4-bit counter: turns a raw, bouncing push-button into clean one-cycle step pulses.
- Those pulses drive the counter's increment/enable input.
- Path: 2-flop synchronizer, then a debounce filter, then a press/auto-repeat FSM.
- One press gives exactly one step. Holding the button gives auto-repeat steps after an initial delay.

---
 rtl/step_pulse_pkg.sv | 23 ++
 rtl/step_pulse_gen_debounce.sv | 51 +++++
 rtl/step_pulse_gen.sv | 99 +++++++++
 3 files changed

// File: rtl/step_pulse_pkg.sv
// Shared types and default timing constants for the push-button step generator.
// Latency: n/a (types and constants only).
// Backpressure: none; consumers of step cannot stall it.
package step_pulse_pkg;

  // Press/auto-repeat FSM states; the encoding is fixed so it can be probed externally.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    REPEAT = 2'd2
  } fsm_state_t;

  // Default timing, in core clock cycles.
  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_REPEAT_DELAY    = 64;
  localparam int DEF_REPEAT_PERIOD   = 16;

  // Elaboration-time helper for sizing the shared repeat timer.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/step_pulse_gen_debounce.sv
// Synchronizes a raw button level and accepts a new level only after it has been stable long enough.
// Latency: DEBOUNCE_CYCLES+1 edges from first sampled change to stable updating.
// Backpressure: none; free-running filter.
module btn_debounce
  import step_pulse_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic stable
);

  // Counter only ever counts up to DEBOUNCE_CYCLES-1 before either clearing or committing,
  // so this width can never wrap.
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // Two-flop synchronizer for the asynchronous button input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

  // Count consecutive cycles where the synchronized level disagrees with the accepted level;
  // any agreement restarts the count, so short glitches never reach stable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else if (sync2 == stable) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      stable <= sync2;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/step_pulse_gen.sv
// Turns a bouncing push-button into single-cycle step pulses with hold-to-repeat.
// Latency: first step DEBOUNCE_CYCLES+2 edges after the first high sample; repeats after REPEAT_DELAY then every REPEAT_PERIOD.
// Backpressure: none; en only masks step, the timing keeps running underneath.
module step_pulse_gen
  import step_pulse_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  input  logic en,
  output logic step,
  output logic held,
  output logic rpt_active
);

  // One timer serves both the initial delay and the repeat period, so it is sized for the larger.
  localparam int TW = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [TW-1:0] DELAY_LAST  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);

  logic          stable;
  logic          stable_d;
  logic          rise;
  logic [TW-1:0] timer;
  fsm_state_t    state;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .reset  (reset),
    .btn_in (btn_in),
    .stable (stable)
  );

  assign held = stable;
  assign rise = stable && !stable_d;

  // Press/auto-repeat FSM. A release is checked before any timer expiry so a button let go
  // on the boundary never yields a late step. step defaults low, which together with
  // REPEAT_DELAY/REPEAT_PERIOD >= 2 keeps pulses at least one idle cycle apart.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      timer      <= '0;
      step       <= 1'b0;
      rpt_active <= 1'b0;
      stable_d   <= 1'b0;
    end else begin
      stable_d <= stable;
      step     <= 1'b0;
      if (!stable) begin
        state      <= IDLE;
        timer      <= '0;
        rpt_active <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            rpt_active <= 1'b0;
            if (rise) begin
              step  <= en;
              timer <= '0;
              state <= WAIT;
            end
          end
          WAIT: begin
            if (timer == DELAY_LAST) begin
              step       <= en;
              timer      <= '0;
              state      <= REPEAT;
              rpt_active <= 1'b1;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          REPEAT: begin
            rpt_active <= 1'b1;
            if (timer == PERIOD_LAST) begin
              step  <= en;
              timer <= '0;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          default: begin
            state      <= IDLE;
            timer      <= '0;
            rpt_active <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
